// File: rtl/mux_sel_arbiter_pkg.sv
// Shared encodings for the A/B request arbiter that steers the 2:1 data mux.
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_mux2.sv
// One-bit 2:1 mux: sel=0 passes a, sel=1 passes b.
module mux_sel_arbiter_mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for two valid/ready streams into a single registered
// output beat, with a bounded burst of HOLD_MAX beats per owner under contention.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          sel,
  output logic          y_valid,
  output logic [DW-1:0] y_data,
  input  logic          y_ready
);

  localparam int            CW       = $clog2(HOLD_MAX + 1);
  localparam logic [CW:0]   HOLD_LIM = (CW + 1)'(HOLD_MAX);

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW:0]   cnt_inc;
  logic [CW-1:0] cnt_sat;
  logic [DW-1:0] mux_y;
  logic          can_acc, own_a, own_b, accept;
  logic          x_valid, o_valid;
  state_t        other;

  // Datapath: bit-sliced mux instances steered by the registered owner.
  for (genvar i = 0; i < DW; i++) begin : g_mux
    mux_sel_arbiter_mux2 u_mux (
      .a   (a_data[i]),
      .b   (b_data[i]),
      .sel (sel),
      .y   (mux_y[i])
    );
  end

  assign own_a   = (state == OWN_A);
  assign own_b   = (state == OWN_B);
  assign sel     = own_b ? SEL_B : SEL_A;
  assign can_acc = !y_valid || y_ready;
  assign a_ready = rst_n && own_a && can_acc;
  assign b_ready = rst_n && own_b && can_acc;
  assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

  assign x_valid = own_b ? b_valid : a_valid;
  assign o_valid = own_b ? a_valid : b_valid;
  assign other   = own_a ? OWN_B : OWN_A;

  assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);
  assign cnt_sat = (cnt_inc > HOLD_LIM) ? cnt : cnt_inc[CW-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) begin
          state_nxt = (last == SEL_B) ? OWN_A : OWN_B;
          cnt_nxt   = '0;
        end else if (a_valid) begin
          state_nxt = OWN_A;
          cnt_nxt   = '0;
        end else if (b_valid) begin
          state_nxt = OWN_B;
          cnt_nxt   = '0;
        end
      end
      OWN_A, OWN_B: begin
        if (!x_valid) begin
          state_nxt = o_valid ? other : IDLE;
          cnt_nxt   = '0;
          last_nxt  = sel;
        end else if (accept) begin
          // >= rather than == so a count saturated while alone still yields
          // to the other side on the first contended beat.
          if (o_valid && (cnt_inc >= HOLD_LIM)) begin
            state_nxt = other;
            cnt_nxt   = '0;
            last_nxt  = sel;
          end else begin
            cnt_nxt = cnt_sat;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= SEL_B;
      y_valid <= 1'b0;
      y_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      if (accept) begin
        y_valid <= 1'b1;
        y_data  <= mux_y;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench: vector table for reset, solo streaming and contention, then
// hand sequences for stall, owner drop, idle tie and mid-transfer reset.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, sel, y_valid;
  logic [7:0] y_data;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.DW(8), .HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .sel     (sel),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready)
  );

  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       yr;
    logic       chk;
    logic       ear;
    logic       ebr;
    logic       esel;
    logic       eyv;
    logic [7:0] eyd;
  } vec_t;

  task automatic cmp(input int id, input string what, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL step%0d %s got %0h want %0h", id, what, got, exp);
  endtask

  // Drive at negedge, compare the pre-edge outputs 1ns later.
  task automatic step(input int id, input logic r, input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd, input logic yr, input logic chk,
                      input logic ear, input logic ebr, input logic esel, input logic eyv,
                      input logic [7:0] eyd);
    @(negedge clk);
    rst_n = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    #1;
    if (chk) begin
      cmp(id, "a_ready", {7'd0, a_ready}, {7'd0, ear});
      cmp(id, "b_ready", {7'd0, b_ready}, {7'd0, ebr});
      cmp(id, "sel",     {7'd0, sel},     {7'd0, esel});
      cmp(id, "y_valid", {7'd0, y_valid}, {7'd0, eyv});
      cmp(id, "y_data",  y_data,          eyd);
    end
  endtask

  vec_t tbl[21];

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = '0; b_data = '0;

    //          rst av  ad     bv  bd     yr  chk ar  br  sel yv  yd
    // reset with both requesting
    tbl[0]  = '{1'b0,1'b1,8'hAA,1'b1,8'hBB,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    tbl[1]  = '{1'b0,1'b1,8'hAA,1'b1,8'hBB,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    // only A: grant cycle, then stream past HOLD_MAX with sel held at 0
    tbl[2]  = '{1'b1,1'b1,8'h11,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    tbl[3]  = '{1'b1,1'b1,8'h11,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00};
    tbl[4]  = '{1'b1,1'b1,8'h22,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'h11};
    tbl[5]  = '{1'b1,1'b1,8'h33,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'h22};
    tbl[6]  = '{1'b1,1'b1,8'h44,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'h33};
    tbl[7]  = '{1'b1,1'b1,8'h55,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'h44};
    tbl[8]  = '{1'b1,1'b1,8'h66,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'h55};
    tbl[9]  = '{1'b1,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'h66};
    // reset again so the contention run starts from last=B
    tbl[10] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h66};
    // both valid: 4 A beats, 4 B beats, back to A, no bubbles
    tbl[11] = '{1'b1,1'b1,8'hA1,1'b1,8'hB1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    tbl[12] = '{1'b1,1'b1,8'hA1,1'b1,8'hB1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00};
    tbl[13] = '{1'b1,1'b1,8'hA2,1'b1,8'hB1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'hA1};
    tbl[14] = '{1'b1,1'b1,8'hA3,1'b1,8'hB1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'hA2};
    tbl[15] = '{1'b1,1'b1,8'hA4,1'b1,8'hB1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'hA3};
    tbl[16] = '{1'b1,1'b1,8'hA5,1'b1,8'hB1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'hA4};
    tbl[17] = '{1'b1,1'b1,8'hA5,1'b1,8'hB2,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'hB1};
    tbl[18] = '{1'b1,1'b1,8'hA5,1'b1,8'hB3,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'hB2};
    tbl[19] = '{1'b1,1'b1,8'hA5,1'b1,8'hB4,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'hB3};
    tbl[20] = '{1'b1,1'b1,8'hA5,1'b1,8'hB5,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,8'hB4};

    for (int i = 0; i < 21; i++)
      step(i, tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].yr, tbl[i].chk,
           tbl[i].ear, tbl[i].ebr, tbl[i].esel, tbl[i].eyv, tbl[i].eyd);

    // OWN_A cnt=1 holding A5: stall 3 cycles, count must not advance
    step(101, 1, 1, 8'hA6, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hA5);
    step(102, 1, 1, 8'hA6, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hA5);
    step(103, 1, 1, 8'hA6, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hA5);
    step(104, 1, 1, 8'hA6, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'hA5);
    step(105, 1, 1, 8'hA7, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'hA6);
    // B arrives on A's 4th beat: handover proves cnt stayed frozen
    step(106, 1, 1, 8'hA8, 1, 8'hC1, 1, 1, 1, 0, 0, 1, 8'hA7);
    step(107, 1, 1, 8'hA9, 1, 8'hC1, 1, 1, 0, 1, 1, 1, 8'hA8);
    // B drops while A waits -> OWN_A, then both drop -> IDLE
    step(108, 1, 1, 8'hA9, 0, 8'h00, 1, 1, 0, 1, 1, 1, 8'hC1);
    step(109, 1, 1, 8'hA9, 0, 8'h00, 1, 1, 1, 0, 0, 0, 8'hC1);
    step(110, 1, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'hA9);
    // tie from IDLE with last=A goes to B
    step(111, 1, 1, 8'hAA, 1, 8'hCA, 1, 1, 0, 0, 0, 0, 8'hA9);
    step(112, 1, 1, 8'hAA, 1, 8'hCA, 1, 1, 0, 1, 1, 0, 8'hA9);
    // stalled beat then reset: beat dropped, back to IDLE
    step(113, 1, 0, 8'h00, 1, 8'hCB, 0, 1, 0, 0, 1, 1, 8'hCA);
    step(114, 0, 0, 8'h00, 1, 8'hCB, 0, 1, 0, 0, 1, 1, 8'hCA);
    step(115, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);
    // tie after reset goes to A again
    step(116, 1, 1, 8'h5A, 1, 8'hA5, 1, 1, 0, 0, 0, 0, 8'h00);
    step(117, 1, 1, 8'h5A, 1, 8'hA5, 1, 1, 1, 0, 0, 0, 8'h00);
    step(118, 1, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'h5A);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
